// File: rtl/apu_issuer_pkg.sv
// Shared types and widths for the APU command issuer.
package apu_issuer_pkg;

    localparam int unsigned APU_NUM_OPERANDS = 3;
    localparam int unsigned APU_DATA_W       = 32;
    localparam int unsigned APU_OP_W         = 6;
    localparam int unsigned APU_FLAGS_IN_W   = 15;
    localparam int unsigned APU_FLAGS_OUT_W  = 5;
    localparam int unsigned APU_WDOG_W       = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } apu_issue_state_t;

    typedef struct packed {
        logic [APU_NUM_OPERANDS-1:0][APU_DATA_W-1:0] operands;
        logic [APU_OP_W-1:0]                         op;
        logic [APU_FLAGS_IN_W-1:0]                   flags;
    } apu_cmd_t;

    localparam int unsigned APU_CMD_W = $bits(apu_cmd_t);

endpackage

// File: rtl/apu_issuer_if.sv
// Core-side command/response port and accelerator-side APU port of the issuer.
interface apu_issuer_if #(
    parameter int unsigned DEPTH = 4
);
    import apu_issuer_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                                   cmd_valid;
    logic                                   cmd_ready;
    logic [APU_NUM_OPERANDS*APU_DATA_W-1:0] cmd_operands;
    logic [APU_OP_W-1:0]                    cmd_op;
    logic [APU_FLAGS_IN_W-1:0]              cmd_flags;

    logic                                   resp_valid;
    logic                                   resp_ready;
    logic [APU_DATA_W-1:0]                  resp_result;
    logic [APU_FLAGS_OUT_W-1:0]             resp_flags;
    logic                                   resp_timeout;

    logic                                   busy;
    logic [CNT_W-1:0]                       fifo_count;

    logic                                   apu_req;
    logic [APU_DATA_W-1:0]                  apu_operands [APU_NUM_OPERANDS];
    logic [APU_OP_W-1:0]                    apu_op;
    logic [APU_FLAGS_IN_W-1:0]              apu_flags_i;
    logic                                   apu_gnt;
    logic                                   apu_rvalid;
    logic [APU_DATA_W-1:0]                  apu_result;
    logic [APU_FLAGS_OUT_W-1:0]             apu_flags_o;

    modport master (
        input  cmd_valid, cmd_operands, cmd_op, cmd_flags,
        output cmd_ready,
        output resp_valid, resp_result, resp_flags, resp_timeout,
        input  resp_ready,
        output busy, fifo_count,
        output apu_req, apu_operands, apu_op, apu_flags_i,
        input  apu_gnt, apu_rvalid, apu_result, apu_flags_o
    );

    modport slave (
        output cmd_valid, cmd_operands, cmd_op, cmd_flags,
        input  cmd_ready,
        input  resp_valid, resp_result, resp_flags, resp_timeout,
        output resp_ready,
        input  busy, fifo_count,
        input  apu_req, apu_operands, apu_op, apu_flags_i,
        output apu_gnt, apu_rvalid, apu_result, apu_flags_o
    );

endinterface

// File: rtl/apu_cmd_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module apu_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/apu_issuer.sv
// Buffers core vector commands and issues them one at a time to the APU,
// returning results (or a watchdog timeout) over a valid/ready response port.
module apu_issuer
    import apu_issuer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    apu_issuer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    apu_issue_state_t            r_state;
    apu_issue_state_t            w_state_nxt;
    apu_cmd_t                    w_push_data;
    apu_cmd_t                    w_head;
    logic [APU_CMD_W-1:0]        w_head_bits;
    apu_cmd_t                    r_launch;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [CNT_W-1:0]            w_count;
    logic [APU_WDOG_W-1:0]       r_wdog;
    logic [APU_DATA_W-1:0]       r_result;
    logic [APU_FLAGS_OUT_W-1:0]  r_flags;
    logic                        r_timeout;
    logic                        w_capture;
    logic                        w_expire;
    logic                        w_wdog_clr;
    logic                        w_req;

    assign w_push_data.operands = bus.cmd_operands;
    assign w_push_data.op       = bus.cmd_op;
    assign w_push_data.flags    = bus.cmd_flags;
    assign w_push               = bus.cmd_valid && !w_full;
    assign w_head               = apu_cmd_t'(w_head_bits);

    apu_cmd_fifo #(
        .WIDTH (APU_CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An rvalid in the final WAIT cycle takes priority over watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        w_wdog_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.apu_gnt) begin
                    if (bus.apu_rvalid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_wdog_clr  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.apu_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_wdog == APU_WDOG_W'(TIMEOUT - 1)) begin
                    w_expire    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_launch  <= '0;
            r_wdog    <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_pop) begin
                r_launch <= w_head;
            end
            if (w_wdog_clr) begin
                r_wdog <= '0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + APU_WDOG_W'(1);
            end
            if (w_capture) begin
                r_result  <= bus.apu_result;
                r_flags   <= bus.apu_flags_o;
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_result  <= '0;
                r_flags   <= '0;
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_req = (r_state == REQ);

    // Payload is gated to zero whenever no request is presented.
    always_comb begin
        bus.apu_req = w_req;
        for (int unsigned i = 0; i < APU_NUM_OPERANDS; i++) begin
            bus.apu_operands[i] = w_req ? r_launch.operands[i] : '0;
        end
        bus.apu_op      = w_req ? r_launch.op    : '0;
        bus.apu_flags_i = w_req ? r_launch.flags : '0;
    end

    assign bus.cmd_ready    = !w_full;
    assign bus.resp_valid   = (r_state == RESP);
    assign bus.resp_result  = r_result;
    assign bus.resp_flags   = r_flags;
    assign bus.resp_timeout = r_timeout;
    assign bus.busy         = (r_state != IDLE) || !w_empty;
    assign bus.fifo_count   = w_count;

endmodule
